// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared FSM encodings, access-size codes and size decode for
//               the byte-serialising memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_MEM_RD = 2'd1;
   localparam logic [1:0] ST_MEM_WR = 2'd2;
   localparam logic [1:0] ST_IF_RD  = 2'd3;

   typedef enum logic [1:0] {
      MEM_SIZE_BYTE = 2'd0,
      MEM_SIZE_HALF = 2'd1,
      MEM_SIZE_WORD = 2'd2,
      MEM_SIZE_RSVD = 2'd3
   } mem_size_e;

   // Index of the final byte of an access; the reserved code behaves as a word.
   function automatic logic [1:0] size_last_idx(input logic [1:0] size);
      case (size)
         MEM_SIZE_BYTE: return 2'd0;
         MEM_SIZE_HALF: return 2'd1;
         default:       return 2'd3;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : CPU-side request/response and RAM-side byte port bundle of
//               the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [31:0]       if_rdata;
   logic              if_done;
   logic              mem_req;
   logic              mem_we;
   logic [1:0]        mem_size;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_done;
   logic              busy;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_dout;
   logic              ram_wr;
   logic [7:0]        ram_din;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
      output if_rdata, if_done, mem_rdata, mem_done, busy, ram_addr, ram_dout, ram_wr
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
      input  if_rdata, if_done, mem_rdata, mem_done, busy, ram_addr, ram_dout, ram_wr
   );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one byte-wide RAM port between instruction fetch and
//               the MEM stage, serialising 1/2/4-byte accesses into bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);

   logic [1:0]        state_q,     state_d;
   logic [1:0]        cnt_q,       cnt_d;
   logic [1:0]        last_q,      last_d;
   logic              lead_q,      lead_d;
   logic [31:0]       asm_q,       asm_d;
   logic [31:0]       wdata_q,     wdata_d;
   logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
   logic [7:0]        ram_dout_q,  ram_dout_d;
   logic              ram_wr_q,    ram_wr_d;
   logic              if_done_q,   if_done_d;
   logic              mem_done_q,  mem_done_d;
   logic [31:0]       if_rdata_q,  if_rdata_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;

   logic [1:0]  cnt_inc;
   logic [31:0] asm_in;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      lead_d      = lead_q;
      asm_d       = asm_q;
      wdata_d     = wdata_q;
      ram_addr_d  = ram_addr_q;
      ram_dout_d  = ram_dout_q;
      ram_wr_d    = 1'b0;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      cnt_inc     = cnt_q + 2'd1;
      asm_in      = asm_q;
      asm_in[{cnt_q, 3'b000} +: 8] = bus.ram_din;

      case (state_q)
         ST_IDLE: begin
            // A done pulse is a dead cycle so the finished requester can drop its request.
            if (!if_done_q && !mem_done_q && (bus.mem_req || bus.if_req)) begin
               cnt_d  = 2'd0;
               lead_d = 1'b1;
               asm_d  = 32'd0;
               if (bus.mem_req) begin
                  state_d    = bus.mem_we ? ST_MEM_WR : ST_MEM_RD;
                  ram_addr_d = bus.mem_addr;
                  last_d     = size_last_idx(bus.mem_size);
                  wdata_d    = bus.mem_wdata;
                  ram_dout_d = bus.mem_wdata[7:0];
                  ram_wr_d   = bus.mem_we;
               end else begin
                  state_d    = ST_IF_RD;
                  ram_addr_d = bus.if_addr;
                  last_d     = 2'd3;
               end
            end
         end

         ST_MEM_WR: begin
            if (cnt_q == last_q) begin
               state_d    = ST_IDLE;
               mem_done_d = 1'b1;
            end else begin
               cnt_d      = cnt_inc;
               ram_addr_d = ram_addr_q + ADDR_W'(1);
               ram_dout_d = wdata_q[{cnt_inc, 3'b000} +: 8];
               ram_wr_d   = 1'b1;
            end
         end

         ST_MEM_RD, ST_IF_RD: begin
            // Read data trails the address by one cycle, so the first cycle only issues.
            if (lead_q) begin
               lead_d     = 1'b0;
               ram_addr_d = ram_addr_q + ADDR_W'(1);
            end else begin
               asm_d = asm_in;
               if (cnt_q == last_q) begin
                  state_d = ST_IDLE;
                  if (state_q == ST_IF_RD) begin
                     if_done_d  = 1'b1;
                     if_rdata_d = asm_in;
                  end else begin
                     mem_done_d  = 1'b1;
                     mem_rdata_d = asm_in;
                  end
               end else begin
                  cnt_d      = cnt_inc;
                  ram_addr_d = ram_addr_q + ADDR_W'(1);
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 2'd0;
         last_q      <= 2'd0;
         lead_q      <= 1'b0;
         asm_q       <= 32'd0;
         wdata_q     <= 32'd0;
         ram_addr_q  <= '0;
         ram_dout_q  <= 8'd0;
         ram_wr_q    <= 1'b0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         if_rdata_q  <= 32'd0;
         mem_rdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         lead_q      <= lead_d;
         asm_q       <= asm_d;
         wdata_q     <= wdata_d;
         ram_addr_q  <= ram_addr_d;
         ram_dout_q  <= ram_dout_d;
         ram_wr_q    <= ram_wr_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign bus.if_rdata  = if_rdata_q;
   assign bus.if_done   = if_done_q;
   assign bus.mem_rdata = mem_rdata_q;
   assign bus.mem_done  = mem_done_q;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_dout  = ram_dout_q;
   assign bus.ram_wr    = ram_wr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a
//               one-cycle-latency byte RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Byte RAM aliased on the low 11 address bits; preload goes through the same port.
   logic [7:0]  mem [0:2047];
   logic        pl_en;
   logic [31:0] pl_addr;
   logic [7:0]  pl_data;

   always @(posedge clk) begin
      bus.ram_din <= mem[bus.ram_addr[10:0]];
      if (pl_en)
         mem[pl_addr[10:0]] <= pl_data;
      else if (bus.ram_wr)
         mem[bus.ram_addr[10:0]] <= bus.ram_dout;
   end

   task automatic ram_load(input logic [31:0] a, input logic [7:0] d);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      @(negedge clk);
      pl_en   = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({bus.busy, bus.if_done, bus.mem_done, bus.ram_wr} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_flags: got %b want 0000", {bus.busy, bus.if_done, bus.mem_done, bus.ram_wr});
      end
      vectors++;
      if ({bus.ram_addr, bus.ram_dout} !== 40'd0) begin
         miscompares++;
         $display("FAIL reset_ram_port: got %h/%h want 0/0", bus.ram_addr, bus.ram_dout);
      end
      vectors++;
      if ({bus.if_rdata, bus.mem_rdata} !== 64'd0) begin
         miscompares++;
         $display("FAIL reset_rdata: got %h/%h want 0/0", bus.if_rdata, bus.mem_rdata);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_word_read;
      ram_load(32'h100, 8'h13);
      ram_load(32'h101, 8'h05);
      ram_load(32'h102, 8'h00);
      ram_load(32'h103, 8'h00);
      bus.if_addr = 32'h100;
      bus.if_req  = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k <= 4) begin
            vectors++;
            if (bus.ram_addr !== 32'(32'h100 + k - 1)) begin
               miscompares++;
               $display("FAIL word_read_addr k=%0d: got %h want %h", k, bus.ram_addr, 32'h100 + k - 1);
            end
         end
         vectors++;
         if (bus.if_done !== 1'(k == 6)) begin
            miscompares++;
            $display("FAIL word_read_done k=%0d: got %b want %b", k, bus.if_done, k == 6);
         end
         if (k == 6) begin
            vectors++;
            if (bus.if_rdata !== 32'h0000_0513) begin
               miscompares++;
               $display("FAIL word_read_data: got %h want 00000513", bus.if_rdata);
            end
            bus.if_req = 1'b0;
         end
      end
      @(negedge clk);
      vectors++;
      if ({bus.if_done, bus.busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL word_read_after: got done,busy=%b want 00", {bus.if_done, bus.busy});
      end
   endtask

   task automatic test_reserved_size;
      ram_load(32'h300, 8'h78);
      ram_load(32'h301, 8'h56);
      ram_load(32'h302, 8'h34);
      ram_load(32'h303, 8'h12);
      bus.mem_addr = 32'h300;
      bus.mem_size = MEM_SIZE_RSVD;
      bus.mem_we   = 1'b0;
      bus.mem_req  = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         vectors++;
         if (bus.mem_done !== 1'(k == 6)) begin
            miscompares++;
            $display("FAIL rsvd_size_done k=%0d: got %b want %b", k, bus.mem_done, k == 6);
         end
      end
      vectors++;
      if (bus.mem_rdata !== 32'h1234_5678) begin
         miscompares++;
         $display("FAIL rsvd_size_data: got %h want 12345678", bus.mem_rdata);
      end
      bus.mem_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_half_wrap;
      ram_load(32'hFFFF_FFFF, 8'h34);
      ram_load(32'h0000_0000, 8'h12);
      bus.mem_addr = 32'hFFFF_FFFF;
      bus.mem_size = MEM_SIZE_HALF;
      bus.mem_we   = 1'b0;
      bus.mem_req  = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1 || k == 2) begin
            vectors++;
            if (bus.ram_addr !== ((k == 1) ? 32'hFFFF_FFFF : 32'h0)) begin
               miscompares++;
               $display("FAIL half_wrap_addr k=%0d: got %h", k, bus.ram_addr);
            end
         end
         vectors++;
         if (bus.mem_done !== 1'(k == 4)) begin
            miscompares++;
            $display("FAIL half_wrap_done k=%0d: got %b want %b", k, bus.mem_done, k == 4);
         end
      end
      vectors++;
      if (bus.mem_rdata !== 32'h0000_1234) begin
         miscompares++;
         $display("FAIL half_wrap_data: got %h want 00001234", bus.mem_rdata);
      end
      bus.mem_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_tie;
      logic [31:0] wd;
      wd = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) ram_load(32'(32'h200 + i), 8'h00);
      bus.if_addr   = 32'h300;
      bus.if_req    = 1'b1;
      bus.mem_addr  = 32'h200;
      bus.mem_size  = MEM_SIZE_WORD;
      bus.mem_we    = 1'b1;
      bus.mem_wdata = wd;
      bus.mem_req   = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         vectors++;
         if (bus.ram_wr !== 1'(k <= 4)) begin
            miscompares++;
            $display("FAIL tie_wr k=%0d: got %b want %b", k, bus.ram_wr, k <= 4);
         end
         if (k <= 4) begin
            vectors++;
            if ({bus.ram_addr, bus.ram_dout} !== {32'(32'h200 + k - 1), wd[8*(k-1) +: 8]}) begin
               miscompares++;
               $display("FAIL tie_wbyte k=%0d: got %h/%h want %h/%h", k, bus.ram_addr, bus.ram_dout,
                        32'h200 + k - 1, wd[8*(k-1) +: 8]);
            end
         end
         if (k == 7) begin
            vectors++;
            if (bus.ram_addr !== 32'h300) begin
               miscompares++;
               $display("FAIL tie_if_grant: got addr %h want 00000300", bus.ram_addr);
            end
         end
         vectors++;
         if ({bus.mem_done, bus.if_done} !== {1'(k == 5), 1'(k == 12)}) begin
            miscompares++;
            $display("FAIL tie_done k=%0d: got mem,if=%b%b", k, bus.mem_done, bus.if_done);
         end
         if (k == 5) bus.mem_req = 1'b0;
         if (k == 12) begin
            vectors++;
            if (bus.if_rdata !== 32'h1234_5678) begin
               miscompares++;
               $display("FAIL tie_if_data: got %h want 12345678", bus.if_rdata);
            end
            bus.if_req = 1'b0;
         end
      end
      vectors++;
      if ({mem[11'h203], mem[11'h202], mem[11'h201], mem[11'h200]} !== wd) begin
         miscompares++;
         $display("FAIL tie_ram: got %h want deadbeef", {mem[11'h203], mem[11'h202], mem[11'h201], mem[11'h200]});
      end
      @(negedge clk);
   endtask

   task automatic test_store_byte;
      ram_load(32'h3, 8'h00);
      ram_load(32'h4, 8'h77);
      bus.mem_addr  = 32'h3;
      bus.mem_size  = MEM_SIZE_BYTE;
      bus.mem_we    = 1'b1;
      bus.mem_wdata = 32'h1234_56A5;
      bus.mem_req   = 1'b1;
      @(negedge clk);
      vectors++;
      if ({bus.ram_wr, bus.busy, bus.mem_done, bus.ram_addr, bus.ram_dout} !== {3'b110, 32'h3, 8'hA5}) begin
         miscompares++;
         $display("FAIL sb_slot: got wr,busy,done=%b%b%b addr=%h dout=%h want 110/3/a5",
                  bus.ram_wr, bus.busy, bus.mem_done, bus.ram_addr, bus.ram_dout);
      end
      @(negedge clk);
      vectors++;
      if ({bus.ram_wr, bus.busy, bus.mem_done} !== 3'b001) begin
         miscompares++;
         $display("FAIL sb_done: got wr,busy,done=%b%b%b want 001", bus.ram_wr, bus.busy, bus.mem_done);
      end
      bus.mem_req = 1'b0;
      @(negedge clk);
      vectors++;
      if ({mem[11'h3], mem[11'h4], bus.mem_done} !== {8'hA5, 8'h77, 1'b0}) begin
         miscompares++;
         $display("FAIL sb_ram: got %h %h done=%b want a5 77 0", mem[11'h3], mem[11'h4], bus.mem_done);
      end
   endtask

   task automatic test_no_preempt;
      bus.if_addr  = 32'h300;
      bus.if_req   = 1'b1;
      bus.mem_addr = 32'h101;
      bus.mem_size = MEM_SIZE_BYTE;
      bus.mem_we   = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         vectors++;
         if ({bus.if_done, bus.mem_done} !== {1'(k == 6), 1'(k == 10)}) begin
            miscompares++;
            $display("FAIL nopre_done k=%0d: got if,mem=%b%b", k, bus.if_done, bus.mem_done);
         end
         if (k == 2) bus.mem_req = 1'b1;
         if (k == 6) begin
            vectors++;
            if (bus.if_rdata !== 32'h1234_5678) begin
               miscompares++;
               $display("FAIL nopre_if_data: got %h want 12345678", bus.if_rdata);
            end
            bus.if_req = 1'b0;
         end
         if (k == 7) begin
            vectors++;
            if (bus.busy !== 1'b0) begin
               miscompares++;
               $display("FAIL nopre_dead: got busy=%b want 0", bus.busy);
            end
         end
         if (k == 8) begin
            vectors++;
            if ({bus.busy, bus.ram_addr} !== {1'b1, 32'h101}) begin
               miscompares++;
               $display("FAIL nopre_mem_grant: got busy=%b addr=%h want 1/00000101", bus.busy, bus.ram_addr);
            end
         end
         if (k == 10) begin
            vectors++;
            if (bus.mem_rdata !== 32'h0000_0005) begin
               miscompares++;
               $display("FAIL nopre_mem_data: got %h want 00000005", bus.mem_rdata);
            end
            bus.mem_req = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_write;
      for (int i = 0; i < 4; i++) ram_load(32'(32'h400 + i), 8'h00);
      bus.mem_addr  = 32'h400;
      bus.mem_size  = MEM_SIZE_WORD;
      bus.mem_we    = 1'b1;
      bus.mem_wdata = 32'hCAFE_F00D;
      bus.mem_req   = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({bus.ram_wr, bus.ram_addr} !== {1'b1, 32'h402}) begin
         miscompares++;
         $display("FAIL rstmid_slot: got wr=%b addr=%h want 1/00000402", bus.ram_wr, bus.ram_addr);
      end
      rst         = 1'b1;
      bus.mem_req = 1'b0;
      @(negedge clk);
      vectors++;
      if ({bus.ram_wr, bus.busy, bus.mem_done} !== 3'b000) begin
         miscompares++;
         $display("FAIL rstmid_next: got wr,busy,done=%b%b%b want 000", bus.ram_wr, bus.busy, bus.mem_done);
      end
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({bus.busy, bus.mem_done} !== 2'b00) begin
         miscompares++;
         $display("FAIL rstmid_after: got busy,done=%b%b want 00", bus.busy, bus.mem_done);
      end
      vectors++;
      if ({mem[11'h403], mem[11'h401], mem[11'h400]} !== 24'h00_F00D) begin
         miscompares++;
         $display("FAIL rstmid_ram: got %h %h %h want 00 f0 0d", mem[11'h403], mem[11'h401], mem[11'h400]);
      end
   endtask

   initial begin
      rst           = 1'b1;
      pl_en         = 1'b0;
      pl_addr       = 32'd0;
      pl_data       = 8'd0;
      bus.if_req    = 1'b0;
      bus.if_addr   = 32'd0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_size  = 2'd0;
      bus.mem_addr  = 32'd0;
      bus.mem_wdata = 32'd0;
      @(negedge clk);
      test_reset;
      test_word_read;
      test_reserved_size;
      test_half_wrap;
      test_tie;
      test_store_byte;
      test_no_preempt;
      test_reset_mid_write;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule

`default_nettype wire
